// File: rtl/line_window_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : line_window_buffer_pkg
// Description : Shared constants and window-indexing helper for the
//               line window buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package line_window_buffer_pkg;

    // Width of the per-row beat counter.
    localparam int c_CNT_W = 11;

    // Bit offset of window element (r,c) in a row-major flattened window.
    function automatic int win_off(input int r, input int c,
                                   input int win_w, input int pix_w);
        return (r * win_w + c) * pix_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/line_window_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : line_window_buffer_if
// Description : Beat input / window output bundle of the line window buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface line_window_buffer_if #(
    parameter int KER_SIZE          = 3,
    parameter int NO_PARALLEL_UNITS = 4,
    parameter int PIX_W             = 8
);
    localparam int c_WIN_W = NO_PARALLEL_UNITS + KER_SIZE - 1;

    logic                                   stall;
    logic [NO_PARALLEL_UNITS*PIX_W-1:0]     in_pix;
    logic [KER_SIZE-2:0]                    rowend;
    logic                                   win_valid;
    logic [KER_SIZE*c_WIN_W*PIX_W-1:0]      win_pix;
    logic                                   row_sync_err;

    // Upstream pixel source / window consumer side.
    modport master (
        output stall, in_pix, rowend,
        input  win_valid, win_pix, row_sync_err
    );

    // Line window buffer side.
    modport slave (
        input  stall, in_pix, rowend,
        output win_valid, win_pix, row_sync_err
    );

endinterface

`default_nettype wire

// File: rtl/line_window_buffer_line_mem_rf.sv
`default_nettype none
// ============================================================================
// Module      : line_mem_rf
// Description : Single-port read-first line memory. Read data is the value
//               stored at i_addr before any write in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module line_mem_rf #(
    parameter int DEPTH  = 130,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  wire logic              clk,
    input  wire logic              en,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [WIDTH-1:0]  i_wdata,
    output logic      [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Asynchronous read returns the old word while the new one is written.
    assign o_rdata = r_mem[i_addr];

    // Write the new row beat at the current column.
    always_ff @(posedge clk) begin
        if (en) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/line_window_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_window_buffer
// Description : Buffers KER_SIZE-1 previous image rows and emits, per accepted
//               beat, a KER_SIZE x (P+KER_SIZE-1) pixel window for the parallel
//               convolution units. Output is gated until enough rows are held.
// Revision    : 1.0 - initial release
// ============================================================================
module line_window_buffer
    import line_window_buffer_pkg::*;
#(
    parameter int IM_LEN            = 520,
    parameter int KER_SIZE          = 3,
    parameter int NO_PARALLEL_UNITS = 4,
    parameter int PIX_W             = 8
) (
    input  wire logic            clk,
    input  wire logic            res,
    input  wire logic            clrbuffer,
    line_window_buffer_if.slave  bus
);

    localparam int c_P     = NO_PARALLEL_UNITS;
    localparam int c_BEATS = IM_LEN / c_P;
    localparam int c_WIN_W = c_P + KER_SIZE - 1;
    localparam int c_AW    = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_RS_W  = $clog2(KER_SIZE + 1);
    localparam int c_ROW_W = c_P * PIX_W;
    localparam int c_CAR_W = (KER_SIZE - 1) * PIX_W;
    localparam int c_WB_W  = KER_SIZE * c_WIN_W * PIX_W;

    logic                 w_accept;
    logic                 w_clr;
    logic                 w_rowend_beat;
    logic                 w_mem_en;
    logic [c_ROW_W-1:0]   w_rd  [KER_SIZE-1];
    logic [c_ROW_W-1:0]   w_wr  [KER_SIZE-1];
    logic [c_ROW_W-1:0]   w_row [KER_SIZE];
    logic [c_WB_W-1:0]    w_win;

    logic [c_CNT_W-1:0]   r_col_cnt;
    logic [c_RS_W-1:0]    r_rows_seen;
    logic                 r_first;
    logic [c_CAR_W-1:0]   r_carry [KER_SIZE];
    logic [c_WB_W-1:0]    r_win_pix;
    logic                 r_win_valid;
    logic                 r_sync_err;

    assign w_accept      = !bus.stall;
    assign w_clr         = res | clrbuffer;
    assign w_rowend_beat = w_accept & !bus.rowend[0];
    assign w_mem_en      = w_accept & !w_clr;

    // Bank 0 takes the incoming row; each further bank takes the row the
    // previous bank held, so bank j always holds the row j+1 lines back.
    for (genvar j = 0; j < KER_SIZE - 1; j++) begin : g_bank
        if (j == 0) begin : g_first
            assign w_wr[j] = bus.in_pix;
        end else begin : g_chain
            assign w_wr[j] = w_rd[j-1];
        end

        line_mem_rf #(
            .DEPTH  (c_BEATS),
            .WIDTH  (c_ROW_W),
            .ADDR_W (c_AW)
        ) u_mem (
            .clk     (clk),
            .en      (w_mem_en),
            .i_addr  (r_col_cnt[c_AW-1:0]),
            .i_wdata (w_wr[j]),
            .o_rdata (w_rd[j])
        );
    end

    // Window row KER_SIZE-1 is the live beat; row 0 is the oldest bank.
    for (genvar r = 0; r < KER_SIZE; r++) begin : g_row
        if (r == KER_SIZE - 1) begin : g_cur
            assign w_row[r] = bus.in_pix;
        end else begin : g_old
            assign w_row[r] = w_rd[KER_SIZE-2-r];
        end
    end

    // Assemble carry columns (zero at row start) followed by the beat lanes.
    always_comb begin
        w_win = '0;
        for (int r = 0; r < KER_SIZE; r++) begin
            w_win[win_off(r, 0, c_WIN_W, PIX_W) +: c_CAR_W] =
                r_first ? '0 : r_carry[r];
            w_win[win_off(r, KER_SIZE-1, c_WIN_W, PIX_W) +: c_ROW_W] = w_row[r];
        end
    end

    // Column tracking, row gating, carry capture and registered window output.
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_col_cnt   <= '0;
            r_rows_seen <= '0;
            r_first     <= 1'b1;
            r_win_pix   <= '0;
            r_win_valid <= 1'b0;
            r_sync_err  <= 1'b0;
            for (int r = 0; r < KER_SIZE; r++) begin
                r_carry[r] <= '0;
            end
        end else if (w_accept) begin
            r_win_valid <= (r_rows_seen == c_RS_W'(KER_SIZE - 1));
            r_win_pix   <= w_win;
            r_first     <= w_rowend_beat;
            for (int r = 0; r < KER_SIZE; r++) begin
                r_carry[r] <= w_row[r][c_ROW_W-1 -: c_CAR_W];
            end
            if (w_rowend_beat) begin
                r_col_cnt <= '0;
                if (r_col_cnt != c_CNT_W'(c_BEATS - 1)) begin
                    r_sync_err <= 1'b1;
                end
                if (r_rows_seen != c_RS_W'(KER_SIZE - 1)) begin
                    r_rows_seen <= r_rows_seen + 1'b1;
                end
            end else begin
                r_col_cnt <= r_col_cnt + 1'b1;
            end
        end else begin
            r_win_valid <= 1'b0;
        end
    end

    assign bus.win_valid    = r_win_valid;
    assign bus.win_pix      = r_win_pix;
    assign bus.row_sync_err = r_sync_err;

endmodule

`default_nettype wire

// File: tb/tb_line_window_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_window_buffer
// Description : Self-checking bench for line_window_buffer with a small
//               window model and an expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_window_buffer;

    localparam int c_IM_LEN = 16;
    localparam int c_P      = 4;
    localparam int c_K      = 3;
    localparam int c_PIX_W  = 8;
    localparam int c_BEATS  = c_IM_LEN / c_P;
    localparam int c_WIN_W  = c_P + c_K - 1;
    localparam int c_WB_W   = c_K * c_WIN_W * c_PIX_W;

    typedef struct {
        logic              v;
        logic [c_WB_W-1:0] w;
        logic              cw;
    } exp_t;

    logic clk;
    logic res;
    logic clrbuffer;

    line_window_buffer_if #(
        .KER_SIZE          (c_K),
        .NO_PARALLEL_UNITS (c_P),
        .PIX_W             (c_PIX_W)
    ) bus ();

    line_window_buffer #(
        .IM_LEN            (c_IM_LEN),
        .KER_SIZE          (c_K),
        .NO_PARALLEL_UNITS (c_P),
        .PIX_W             (c_PIX_W)
    ) u_dut (
        .clk       (clk),
        .res       (res),
        .clrbuffer (clrbuffer),
        .bus       (bus)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int                n_chk  = 0;
    int                n_pass = 0;
    exp_t              q[$];
    int                m_rows = 0;
    logic [c_WB_W-1:0] m_win  = '0;
    logic              m_win_ok = 1'b0;

    task automatic chk_val(input string tag, input logic [c_WB_W-1:0] got,
                           input logic [c_WB_W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [c_PIX_W-1:0] pix(input int frame, input int row,
                                               input int col);
        return c_PIX_W'(frame * 128 + row * 16 + col);
    endfunction

    function automatic logic [c_P*c_PIX_W-1:0] beat_pix(input int frame,
                                                        input int row, input int b);
        logic [c_P*c_PIX_W-1:0] v;
        v = '0;
        for (int l = 0; l < c_P; l++) v[l*c_PIX_W +: c_PIX_W] = pix(frame, row, b*c_P + l);
        return v;
    endfunction

    // Reference window: rows fr-K+1..fr, beat b; carry columns zero at b==0.
    function automatic logic [c_WB_W-1:0] exp_window(input int frame, input int fr,
                                                     input int b);
        logic [c_WB_W-1:0] w;
        int row;
        w = '0;
        for (int r = 0; r < c_K; r++) begin
            row = fr - (c_K - 1) + r;
            for (int c = 0; c < c_WIN_W; c++) begin
                if (c >= c_K - 1)
                    w[(r*c_WIN_W + c)*c_PIX_W +: c_PIX_W] = pix(frame, row, b*c_P + c - (c_K-1));
                else if (b != 0)
                    w[(r*c_WIN_W + c)*c_PIX_W +: c_PIX_W] = pix(frame, row, b*c_P - (c_K-1) + c);
            end
        end
        return w;
    endfunction

    // One clock of stimulus: push the expected result, then compare it.
    task automatic step(input logic st, input logic clr, input int frame,
                        input int fr, input int b, input logic force_end,
                        input logic chkwin);
        exp_t e;
        logic row_end;
        row_end      = (b == c_BEATS - 1) || force_end;
        bus.stall    = st;
        clrbuffer    = clr;
        bus.in_pix   = beat_pix(frame, fr, b);
        bus.rowend   = {1'b1, !row_end};
        if (clr) begin
            e.v = 1'b0; e.w = '0; e.cw = 1'b1;
            m_rows = 0; m_win = '0; m_win_ok = 1'b0;
        end else if (st) begin
            e.v = 1'b0; e.w = m_win; e.cw = m_win_ok;
        end else begin
            e.v = (m_rows == c_K - 1);
            if (e.v && chkwin) m_win = exp_window(frame, fr, b);
            m_win_ok = e.v && chkwin;
            e.w  = m_win;
            e.cw = m_win_ok;
            if (row_end && m_rows < c_K - 1) m_rows++;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk_val("win_valid", c_WB_W'(bus.win_valid), c_WB_W'(e.v));
        if (e.cw) chk_val("win_pix", bus.win_pix, e.w);
        clrbuffer = 1'b0;
        bus.stall = 1'b1;
    endtask

    task automatic send_row(input int frame, input int fr);
        for (int b = 0; b < c_BEATS; b++) step(1'b0, 1'b0, frame, fr, b, 1'b0, 1'b1);
    endtask

    initial begin
        res        = 1'b1;
        clrbuffer  = 1'b0;
        bus.stall  = 1'b1;
        bus.in_pix = '0;
        bus.rowend = '1;
        repeat (2) @(posedge clk);
        #1;
        chk_val("rst_valid", c_WB_W'(bus.win_valid), '0);
        chk_val("rst_pix", bus.win_pix, '0);
        chk_val("rst_err", c_WB_W'(bus.row_sync_err), '0);
        res = 1'b0;

        // Fill the line buffers and produce the first valid windows.
        for (int fr = 0; fr < 3; fr++) send_row(0, fr);

        // Row 3 with a stall burst in the middle.
        step(1'b0, 1'b0, 0, 3, 0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 0, 3, 1, 1'b0, 1'b1);
        for (int s = 0; s < 3; s++) step(1'b1, 1'b0, 0, 3, 2, 1'b0, 1'b1);
        step(1'b0, 1'b0, 0, 3, 2, 1'b0, 1'b1);
        step(1'b0, 1'b0, 0, 3, 3, 1'b0, 1'b1);
        step(1'b0, 1'b0, 0, 4, 0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 0, 4, 1, 1'b0, 1'b1);

        // Frame clear with a simultaneous (dropped) beat, then a new frame.
        step(1'b0, 1'b1, 0, 4, 2, 1'b0, 1'b1);
        for (int fr = 0; fr < 3; fr++) send_row(1, fr);
        step(1'b0, 1'b0, 1, 3, 0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1, 3, 1, 1'b0, 1'b1);

        // Early row end at column 2: sticky sync error and restart of the row.
        step(1'b0, 1'b0, 1, 3, 2, 1'b1, 1'b1);
        chk_val("sync_err_set", c_WB_W'(bus.row_sync_err), c_WB_W'(1));
        step(1'b0, 1'b0, 1, 4, 0, 1'b0, 1'b0);
        for (int r = 0; r < c_K; r++)
            chk_val("restart_carry", c_WB_W'(bus.win_pix[r*c_WIN_W*c_PIX_W +: (c_K-1)*c_PIX_W]), '0);
        chk_val("sync_err_hold", c_WB_W'(bus.row_sync_err), c_WB_W'(1));
        for (int b = 1; b < c_BEATS; b++) step(1'b0, 1'b0, 1, 4, b, 1'b0, 1'b0);
        chk_val("sync_err_sticky", c_WB_W'(bus.row_sync_err), c_WB_W'(1));
        step(1'b1, 1'b1, 1, 0, 0, 1'b0, 1'b1);
        chk_val("sync_err_clr", c_WB_W'(bus.row_sync_err), '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
